// File: rtl/psmac_accumulator.sv
// ----------------------------------------------------------------------------
// psmac_accumulator
//   Downstream stage of the OAFU precision-scalable multiplier. It sums a
//   programmed number of signed products into a wide signed result and
//   presents the dot product on a valid/ready result port. Together with the
//   multiplier this forms a full MAC for the 4-bit and 8-bit modes.
//
// Optional feature macro: PSMAC_ACC_SAT_EN
//   defined   -> saturating add with a sticky sat flag
//   undefined -> plain ACC_W-bit wrap-around add, sat tied low
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   start, len             begin an accumulation of len products (IDLE only)
//   prod_valid/ready, prod signed product input stream
//   res_valid/ready, res   signed accumulated result
//   busy                   high while accumulating or holding a result
//   sat                    sticky overflow flag for the current result
// ----------------------------------------------------------------------------
module psmac_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 32,  // sized so len full-scale products cannot overflow
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res,
    output logic              busy,
    output logic              sat
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [ACC_W-1:0] add_res;

`ifdef PSMAC_ACC_SAT_EN
    logic             sat_q, sat_d;
    logic             add_ovf;
    logic [ACC_W:0]   sum_w;

    // One guard bit: overflow iff the guard and the ACC_W sign bit disagree;
    // the guard bit then holds the true sign and picks the clamp direction.
    always_comb begin
        sum_w   = (ACC_W+1)'($signed(acc_q)) + (ACC_W+1)'($signed(prod));
        add_ovf = sum_w[ACC_W] ^ sum_w[ACC_W-1];
        if (!add_ovf)
            add_res = sum_w[ACC_W-1:0];
        else if (sum_w[ACC_W])
            add_res = {1'b1, {(ACC_W-1){1'b0}}};
        else
            add_res = {1'b0, {(ACC_W-1){1'b1}}};
    end

    assign sat = sat_q;
`else
    assign add_res = acc_q + ACC_W'($signed(prod));
    assign sat     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
`ifdef PSMAC_ACC_SAT_EN
        sat_d   = sat_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    len_d   = len;
`ifdef PSMAC_ACC_SAT_EN
                    sat_d   = 1'b0;
`endif
                    state_d = (len == '0) ? S_DONE : S_ACC;
                end
            end
            S_ACC: begin
                if (prod_valid) begin
                    acc_d = add_res;
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef PSMAC_ACC_SAT_EN
                    sat_d = sat_q | add_ovf;
`endif
                    // Exit on the last product so cnt never wraps, even at len=max.
                    if (cnt_q == len_q - CNT_W'(1))
                        state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
`ifdef PSMAC_ACC_SAT_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
`ifdef PSMAC_ACC_SAT_EN
            sat_q   <= sat_d;
`endif
        end
    end

    // Handshake outputs decode straight from state so reset clears them at once.
    assign prod_ready = (state_q == S_ACC);
    assign res_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    // acc only changes in ACC or on a new start, so res holds after handoff.
    assign res        = acc_q;

endmodule

// File: tb/tb_psmac_accumulator.sv
module tb_psmac_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        prod_valid = 1'b0;
    logic        prod_ready;
    logic [15:0] prod = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res;
    logic        busy;
    logic        sat;

    // Narrow-accumulator instance for the overflow case.
    logic        o_start = 1'b0;
    logic [7:0]  o_len = '0;
    logic        o_prod_valid = 1'b0;
    logic        o_prod_ready;
    logic [15:0] o_prod = '0;
    logic        o_res_valid;
    logic        o_res_ready = 1'b0;
    logic [15:0] o_res;
    logic        o_busy;
    logic        o_sat;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        sat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    psmac_accumulator #(.PROD_W(16), .ACC_W(32), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .prod_valid(prod_valid), .prod_ready(prod_ready), .prod(prod),
        .res_valid(res_valid), .res_ready(res_ready), .res(res),
        .busy(busy), .sat(sat)
    );

    psmac_accumulator #(.PROD_W(16), .ACC_W(16), .CNT_W(8)) u_ovf (
        .clk(clk), .rst_n(rst_n), .start(o_start), .len(o_len),
        .prod_valid(o_prod_valid), .prod_ready(o_prod_ready), .prod(o_prod),
        .res_valid(o_res_valid), .res_ready(o_res_ready), .res(o_res),
        .busy(o_busy), .sat(o_sat)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] r, input logic s);
        exp_t e;
        e.res = r;
        e.sat = s;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    // Monitor: every result handshake pops one expectation.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_res", res, e.res);
                check("sb_sat", {31'd0, sat}, {31'd0, e.sat});
            end
        end
    end

    initial begin
        logic signed [15:0] pv [4];
        logic signed [15:0] sv [3];
        pv = '{16'sd100, -16'sd50, 16'sd16129, 16'sd16384};
        sv = '{16'sd7, -16'sd3, 16'sd5};

        // Reset state
        #2;
        check("rst_prod_ready", {31'd0, prod_ready}, 32'd0);
        check("rst_res_valid",  {31'd0, res_valid},  32'd0);
        check("rst_busy",       {31'd0, busy},       32'd0);
        check("rst_res",        res,                 32'd0);
        check("rst_sat",        {31'd0, sat},        32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Basic dot product: 100-50+16129+16384
        push_exp(32'd32563, 1'b0);
        do_start(8'd4);
        check("dp_busy", {31'd0, busy}, 32'd1);
        check("dp_prod_ready", {31'd0, prod_ready}, 32'd1);
        prod_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            prod = pv[i];
            tick();
            if (i == 2) check("dp_no_early_valid", {31'd0, res_valid}, 32'd0);
        end
        prod_valid = 1'b0;
        check("dp_latency_valid", {31'd0, res_valid}, 32'd1);
        check("dp_done_prod_ready", {31'd0, prod_ready}, 32'd0);
        tick();
        check("dp_back_idle", {31'd0, busy}, 32'd0);
        check("dp_valid_drop", {31'd0, res_valid}, 32'd0);
        check("dp_res_kept", res, 32'd32563);
        tick();

        // Stalling producer: 7-3+5 with two-cycle gaps
        push_exp(32'd9, 1'b0);
        do_start(8'd3);
        for (int i = 0; i < 3; i++) begin
            prod_valid = 1'b1;
            prod = sv[i];
            tick();
            prod_valid = 1'b0;
            if (i < 2) begin
                for (int g = 0; g < 2; g++) begin
                    prod = 16'h7fff;  // garbage must not be taken while invalid
                    check("stall_prod_ready", {31'd0, prod_ready}, 32'd1);
                    check("stall_no_valid", {31'd0, res_valid}, 32'd0);
                    tick();
                end
            end
        end
        check("stall_valid", {31'd0, res_valid}, 32'd1);
        tick(); tick();

        // Zero length
        push_exp(32'd0, 1'b0);
        do_start(8'd0);
        check("zero_valid", {31'd0, res_valid}, 32'd1);
        check("zero_prod_ready", {31'd0, prod_ready}, 32'd0);
        tick(); tick();

        // Backpressure: -128*128 held for 5 cycles, stray start ignored
        res_ready = 1'b0;
        push_exp(32'hFFFF_C000, 1'b0);
        do_start(8'd1);
        prod_valid = 1'b1;
        prod = 16'hC000;
        tick();
        prod_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, res_valid}, 32'd1);
            check("bp_res", res, 32'hFFFF_C000);
            check("bp_prod_ready", {31'd0, prod_ready}, 32'd0);
            start = (i == 2);
            len   = 8'd5;
            tick();
        end
        start = 1'b0;
        res_ready = 1'b1;
        tick();
        check("bp_idle", {31'd0, busy}, 32'd0);
        tick();
        check("bp_start_ignored", {31'd0, busy}, 32'd0);

        // Reset mid-operation
        do_start(8'd8);
        prod_valid = 1'b1;
        prod = 16'd11;
        tick(); tick(); tick();
        prod_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_prod_ready", {31'd0, prod_ready}, 32'd0);
        check("mid_rst_res", res, 32'd0);
        check("mid_rst_valid", {31'd0, res_valid}, 32'd0);
        tick();
        #3 rst_n = 1'b1;
        tick();
        push_exp(32'd5, 1'b0);
        do_start(8'd1);
        prod_valid = 1'b1;
        prod = 16'd5;
        tick();
        prod_valid = 1'b0;
        check("post_rst_valid", {31'd0, res_valid}, 32'd1);
        tick(); tick();

        // Overflow on the 16-bit accumulator: 3 x 16384
        o_start = 1'b1;
        o_len = 8'd3;
        tick();
        o_start = 1'b0;
        o_prod_valid = 1'b1;
        o_prod = 16'd16384;
        tick(); tick(); tick();
        o_prod_valid = 1'b0;
        check("ovf_valid", {31'd0, o_res_valid}, 32'd1);
`ifdef PSMAC_ACC_SAT_EN
        check("ovf_res", {16'd0, o_res}, 32'h0000_7FFF);
        check("ovf_sat", {31'd0, o_sat}, 32'd1);
`else
        check("ovf_res", {16'd0, o_res}, 32'h0000_C000);
        check("ovf_sat", {31'd0, o_sat}, 32'd0);
`endif
        o_res_ready = 1'b1;
        tick();
        check("ovf_idle", {31'd0, o_busy}, 32'd0);
        tick();

        check("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/psmac_accumulator.md
Name: psmac_accumulator

Overview:
- Downstream stage of the OAFU precision-scalable multiplier.
- Consumes the 16-bit signed product stream `y` through a valid/ready handshake.
- Accumulates a programmed number of products into a wide signed sum and presents the dot-product result on a second valid/ready port.
- Turns the multiplier into a full MAC for 4-bit and 8-bit operating modes; product width is 16 bits in both modes.

Parameters:
- PROD_W, 16: product input width; matches multiplier output `y`.
- ACC_W, 32: accumulator and result width; must be greater than or equal to PROD_W + CNT_W.
- CNT_W, 8: width of the length field and the product counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin an accumulation; honoured only in IDLE.
- len  input  CNT_W  number of products to accumulate; sampled when start is accepted.
- prod_valid  input  1  product on `prod` is valid.
- prod_ready  output  1  block accepts a product this cycle.
- prod  input  PROD_W  signed product from the multiplier.
- res_valid  output  1  result on `res` is valid.
- res_ready  input  1  consumer accepts the result.
- res  output  ACC_W  signed accumulated result.
- busy  output  1  high in ACC and DONE.
- sat  output  1  sticky overflow flag for the current result.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; acc=0; cnt=0; len_q=0; prod_ready=0; res_valid=0; res=0; busy=0; sat=0. Reset mid-accumulation aborts it immediately; no partial result is emitted.
- State IDLE:
  - prod_ready=0, res_valid=0.
  - start=1 clears acc, cnt and sat, and latches len into len_q.
  - If len==0, go to DONE with acc=0 (result 0 presented the next cycle); otherwise go to ACC.
- State ACC:
  - prod_ready=1.
  - On a handshake (prod_valid & prod_ready): acc <= acc + sign_extend(prod) and cnt <= cnt+1.
  - When a handshake occurs with cnt==len_q-1, go to DONE; the last product is included in acc.
  - When prod_valid=0, acc and cnt hold; there is no timeout.
  - start is ignored.
- State DONE:
  - res_valid=1; res=acc, held stable until handshake; prod_ready=0.
  - On res_valid & res_ready go to IDLE; res_valid drops the next cycle, and res keeps its last value.
  - start in the same cycle as the result handshake is ignored; a new start must come while in IDLE.
- Latency: res_valid rises exactly 1 cycle after the final product handshake. Back-to-back accumulation: a minimum of 2 idle cycles between the result handshake and the first new prod_ready (DONE->IDLE, IDLE->ACC).
- Arithmetic:
  - prod is sign-extended to ACC_W; two's-complement add.
  - Overflow behaviour is defined by the optional feature below.
- busy=1 in ACC and DONE, 0 in IDLE.
- len is max 2^CNT_W-1; cnt never wraps because the ACC exit occurs at len_q-1.

Optional Feature:
- Macro: PSMAC_ACC_SAT_EN.
- Defined:
  - The add saturates to +2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - sat is set on the first clamp and stays set until the next accepted start or reset.
  - Once clamped, subsequent products continue to add from the clamped value; acc never wraps.
- Undefined:
  - Plain ACC_W-bit wrap-around add.
  - sat is tied to 0.

Test Plan:
- Basic dot product: start with len=4; products 100, -50, 127*127=16129, -128*-128=16384 with prod_valid held high -> res_valid rises 1 cycle after the 4th handshake; res=32563; sat=0.
- Stalling producer: start with len=3; products 7, -3, 5 with 2 idle cycles between each -> res=9; acc and cnt hold during the gaps; prod_ready stays 1 throughout ACC.
- Zero length: start with len=0 -> DONE the next cycle with res=0; no prod_ready pulse.
- Backpressure: after a result of -16384 (len=1, prod=-128*128), hold res_ready=0 for 5 cycles -> res_valid and res stay stable; prod_ready=0; a start pulse in DONE is ignored; release res_ready -> IDLE.
- Reset mid-operation: start with len=8; after 3 products pull rst_n low asynchronously, off the clock edge -> all outputs reach reset values immediately. Then start with len=1 and prod=5 -> res=5, with no leftover state.
- Overflow, with ACC_W=16 override and len=3, products 16384 each:
  - With PSMAC_ACC_SAT_EN: res=32767, sat=1.
  - Without PSMAC_ACC_SAT_EN: res=-16384, sat=0.
